// File: rtl/muldiv_defs_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_defs
// Shared definitions for the iterative multiply/divide unit. The control unit
// and the writeback-source selector decode the same operation constants.
//   OP_*      : operation select codes driven on the unit's op port
//   state_t   : FSM state encodings (S_IDLE / S_CALC / S_FIN)
//   op_is_div : true for the two divide-family operations
// -----------------------------------------------------------------------------
package muldiv_defs;

    localparam logic [1:0] OP_MUL  = 2'd0;  // low word of product
    localparam logic [1:0] OP_MULH = 2'd1;  // high word of product
    localparam logic [1:0] OP_DIV  = 2'd2;  // quotient
    localparam logic [1:0] OP_REM  = 2'd3;  // remainder

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // DIV and REM share op[1]; the datapath only needs to know which family.
    function automatic logic op_is_div(input logic [1:0] op_code);
        return op_code[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
//   Multiply: shift-add. {i_acc, i_lo} is the product register; i_lo[0] is the
//             current multiplier bit, i_opnd the multiplicand. The sum is
//             shifted right one place into {o_acc, o_lo}.
//   Divide:   restoring trial subtract. i_acc is the partial remainder, i_lo
//             holds the remaining dividend bits (MSB first) and collects the
//             quotient bits at its LSB. i_opnd is the divisor.
// Ports:
//   i_is_div  select divide (1) or multiply (0) step
//   i_acc     high half / partial remainder
//   i_lo      low half / dividend-quotient shift register
//   i_opnd    multiplicand / divisor
//   o_acc     next high half / partial remainder
//   o_lo      next low half / dividend-quotient shift register
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_defs::*;
#(
    parameter int width = 32
) (
    input  logic             i_is_div,
    input  logic [width-1:0] i_acc,
    input  logic [width-1:0] i_lo,
    input  logic [width-1:0] i_opnd,
    output logic [width-1:0] o_acc,
    output logic [width-1:0] o_lo
);

    logic [width:0]   w_sum;    // multiply: carry + high half
    logic [width:0]   w_shift;  // divide: remainder shifted left with next dividend bit
    logic             w_ge;     // divide: trial subtraction succeeds
    logic [width-1:0] w_diff;   // divide: remainder after a successful subtraction

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves a signal unassigned and no latch is inferred.
        o_acc   = i_acc;
        o_lo    = i_lo;
        w_sum   = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_opnd} : '0);
        w_shift = {i_acc, i_lo[width-1]};
        w_ge    = (w_shift >= {1'b0, i_opnd});
        // When w_ge holds the true difference is below the divisor, so the
        // low width bits of the subtraction are exact.
        w_diff  = w_shift[width-1:0] - i_opnd;

        if (i_is_div) begin
            // A failed trial means w_shift < divisor < 2^width, so its top bit is 0.
            o_acc = w_ge ? w_diff : w_shift[width-1:0];
            o_lo  = {i_lo[width-2:0], w_ge};
        end else begin
            o_acc = w_sum[width:1];
            o_lo  = {w_sum[0], i_lo[width-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter_unit.sv
// -----------------------------------------------------------------------------
// muldiv_iter_unit
// Iterative multiply/divide unit for the execute stage, one radix-2 step per
// clock. Its result feeds din3 of the writeback-source selector, qualified by
// done; the control unit stalls the pipeline while busy is high.
//
// Configuration macro: MULDIV_SIGNED_EN
//   defined   : is_signed=1 runs on operand magnitudes, signs fixed when the
//               result is written (no extra cycle).
//   undefined : is_signed is ignored; every operation is unsigned.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (overrides start and flush)
//   start      request an operation; accepted only in IDLE
//   op         OP_MUL / OP_MULH / OP_DIV / OP_REM
//   is_signed  two's-complement operands (only with MULDIV_SIGNED_EN)
//   a, b       multiplicand/dividend, multiplier/divisor
//   flush      abort an operation in flight; suppresses start in IDLE
//   busy       high while iterating (cycle after acceptance until done)
//   done       one-cycle pulse, result valid
//   result     final value, held until the next operation completes
// -----------------------------------------------------------------------------
module muldiv_iter_unit
    import muldiv_defs::*;
#(
    parameter int width = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             is_signed,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] result
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(width - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_op;
    logic [width-1:0] r_acc;     // product high half / partial remainder
    logic [width-1:0] r_lo;      // product low half / dividend-quotient
    logic [width-1:0] r_opnd;    // multiplicand / divisor magnitude
    logic [CNT_W-1:0] r_cnt;
    logic             r_div0;    // divide by zero: no iterations, fixed result
    logic             r_neg;     // final result must be negated
    logic [width-1:0] r_result;

    logic             w_accept;
    logic             w_finish;
    logic             w_sgn_a;
    logic             w_sgn_b;
    logic [width-1:0] w_mag_a;
    logic [width-1:0] w_mag_b;
    logic [width-1:0] w_step_acc;
    logic [width-1:0] w_step_lo;
    logic [width-1:0] w_raw_hi;
    logic [width-1:0] w_raw_lo;
    logic             w_lo_zero;
    logic [width-1:0] w_fin_res;

    // ---------------------------------------------------------------- signs
`ifdef MULDIV_SIGNED_EN
    assign w_sgn_a = is_signed & a[width-1];
    assign w_sgn_b = is_signed & b[width-1];
`else
    assign w_sgn_a = 1'b0;
    assign w_sgn_b = 1'b0;
    logic w_unused_is_signed;
    assign w_unused_is_signed = is_signed;
`endif

    // The most-negative value maps onto itself, which is its correct unsigned
    // magnitude, so no special case is needed here.
    assign w_mag_a = w_sgn_a ? -a : a;
    assign w_mag_b = w_sgn_b ? -b : b;

    // ------------------------------------------------------------- datapath
    muldiv_step #(.width(width)) u_step (
        .i_is_div (op_is_div(r_op)),
        .i_acc    (r_acc),
        .i_lo     (r_lo),
        .i_opnd   (r_opnd),
        .o_acc    (w_step_acc),
        .o_lo     (w_step_lo)
    );

    // The result register is loaded on the edge that enters FIN, so the final
    // value is taken straight from the last iteration's step outputs. On divide
    // by zero the registers still hold the magnitude of a in r_lo.
    assign w_raw_hi  = r_div0 ? r_lo : w_step_acc;
    assign w_raw_lo  = w_step_lo;
    assign w_lo_zero = (w_raw_lo == '0);

    always_comb begin
        w_fin_res = w_raw_hi;
        case (r_op)
            OP_MUL:  w_fin_res = r_neg ? -w_raw_lo : w_raw_lo;
            // Negating a double-width value: the +1 ripples into the high
            // half only when the low half is zero.
            OP_MULH: w_fin_res = r_neg ? (~w_raw_hi + width'(w_lo_zero)) : w_raw_hi;
            OP_DIV:  w_fin_res = r_div0 ? '1 : (r_neg ? -w_raw_lo : w_raw_lo);
            default: w_fin_res = r_neg ? -w_raw_hi : w_raw_hi;
        endcase
    end

    // ------------------------------------------------------------------ FSM
    assign w_accept = (r_state == S_IDLE) && start && !flush;
    assign w_finish = (r_state == S_CALC) && !flush && (r_div0 || (r_cnt == LAST_ITER));

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !flush) w_state_nxt = S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (flush)         w_state_nxt = S_IDLE;
                else if (w_finish) w_state_nxt = S_FIN;
            end
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            // NOTE: the datapath registers are reset too, so the unit leaves
            // reset in a fully known state rather than only a known FSM state.
            r_state  <= S_IDLE;
            r_op     <= OP_MUL;
            r_acc    <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_div0   <= 1'b0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_op   <= op;
                r_cnt  <= '0;
                r_acc  <= '0;
                r_div0 <= op_is_div(op) && (b == '0);
                r_neg  <= (op == OP_REM) ? w_sgn_a : (w_sgn_a ^ w_sgn_b);
                if (op_is_div(op)) begin
                    r_lo   <= w_mag_a;
                    r_opnd <= w_mag_b;
                end else begin
                    r_lo   <= w_mag_b;
                    r_opnd <= w_mag_a;
                end
            end else if ((r_state == S_CALC) && !r_div0) begin
                r_acc <= w_step_acc;
                r_lo  <= w_step_lo;
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_finish) r_result <= w_fin_res;
        end
    end

    assign result = r_result;

endmodule
